// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: action/state enum, forward-select codes
// and the per-stage tracker entry.
package hazard_ctrl_pkg;

  // Tracker rd is stored at this fixed width; REG_ADDR_W must not exceed it.
  localparam int MAX_ADDR_W = 8;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LD_STALL   = 2'b01,
    FLAG_STALL = 2'b10,
    FLUSH      = 2'b11
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] rd;
    logic                  we;
    logic                  load;
    logic                  set_flags;
  } trk_entry_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. master = pipeline, slave = controller.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_ra, id_rb, id_rd;
  logic                  id_use_ra, id_use_rb;
  logic                  id_we, id_load, id_set_flags, id_cond_br;
  logic                  ex_br_taken;
  logic                  ext_hold;

  logic                  stall_if, stall_id, bubble_ex, flush_id, flush_ex;
  logic [1:0]            fwd_a, fwd_b, state;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  modport master (
    output id_valid, id_ra, id_rb, id_rd, id_use_ra, id_use_rb,
           id_we, id_load, id_set_flags, id_cond_br, ex_br_taken, ext_hold,
    input  stall_if, stall_id, bubble_ex, flush_id, flush_ex,
           fwd_a, fwd_b, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_ra, id_rb, id_rd, id_use_ra, id_use_rb,
           id_we, id_load, id_set_flags, id_cond_br, ex_br_taken, ext_hold,
    output stall_if, stall_id, bubble_ex, flush_id, flush_ex,
           fwd_a, fwd_b, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one source: youngest valid writer among EX/MEM/WB.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic                  use_src,
  input  logic [MAX_ADDR_W-1:0] addr,
  input  trk_entry_t            ex,
  input  trk_entry_t            mem,
  input  trk_entry_t            wb,
  output logic [1:0]            sel
);
  logic unused_ok;
  assign unused_ok = ^{ex.set_flags, mem.load, mem.set_flags, wb.load, wb.set_flags};

  // A load in EX has no data yet; it only becomes a source once it reaches MEM.
  always_comb begin
    sel = FWD_RF;
    if (use_src) begin
      if (ex.valid && ex.we && !ex.load && (ex.rd == addr))  sel = FWD_EX;
      else if (mem.valid && mem.we && (mem.rd == addr))      sel = FWD_MEM;
      else if (wb.valid && wb.we && (wb.rd == addr))         sel = FWD_WB;
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / flag stalls, branch flush, operand forwarding
// and saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);
  trk_entry_t            ex_q, mem_q, wb_q, id_e;
  logic [MAX_ADDR_W-1:0] ra, rb, rd;
  logic                  hold, br, ld_use, flag_haz, hz_stall;
  hz_state_e             state_q, act;
  logic [CNT_W-1:0]      stall_cnt_q, flush_cnt_q;

  assign ra = MAX_ADDR_W'(hif.id_ra[REG_ADDR_W-1:0]);
  assign rb = MAX_ADDR_W'(hif.id_rb[REG_ADDR_W-1:0]);
  assign rd = MAX_ADDR_W'(hif.id_rd[REG_ADDR_W-1:0]);

  assign hold = hif.ext_hold;
  assign br   = hif.ex_br_taken;

  assign ld_use   = hif.id_valid & ex_q.valid & ex_q.load & ex_q.we &
                    ((hif.id_use_ra & (ra == ex_q.rd)) | (hif.id_use_rb & (rb == ex_q.rd)));
  assign flag_haz = hif.id_valid & hif.id_cond_br & ex_q.valid & ex_q.set_flags;
  assign hz_stall = ~br & (ld_use | flag_haz);

  // Gated by reset so hold/branch inputs cannot leak through while reset is high.
  assign hif.stall_if  = ~reset & (hold | hz_stall);
  assign hif.stall_id  = ~reset & (hold | hz_stall);
  assign hif.bubble_ex = ~reset & ~hold & hz_stall;
  assign hif.flush_id  = ~reset & ~hold & br;
  assign hif.flush_ex  = ~reset & ~hold & br;

  always_comb begin
    act = RUN;
    if (br)            act = FLUSH;
    else if (ld_use)   act = LD_STALL;
    else if (flag_haz) act = FLAG_STALL;
  end

  always_comb begin
    id_e           = '0;
    id_e.valid     = hif.id_valid & ~hz_stall & ~br;
    id_e.rd        = rd;
    id_e.we        = hif.id_we;
    id_e.load      = hif.id_load;
    id_e.set_flags = hif.id_set_flags;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!hold) begin
      ex_q    <= id_e;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      state_q <= act;
      if ((act == LD_STALL || act == FLAG_STALL) && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (act == FLUSH && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hif.state     = state_q;
  assign hif.stall_cnt = stall_cnt_q;
  assign hif.flush_cnt = flush_cnt_q;

  hazard_fwd_sel u_fwd_a (
    .use_src (hif.id_use_ra),
    .addr    (ra),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (hif.fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .use_src (hif.id_use_rb),
    .addr    (rb),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (hif.fwd_b)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed program snippets plus random traffic,
// expectations from an instruction-history reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int AW  = 4;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hif();
  hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .hif(hif));

  typedef struct {bit rst, v, ua, ub, we, ld, sf, cb, br, hold; int ra, rb, rd;} stim_t;
  typedef struct {bit v, we, ld, sf; int rd;} ins_t;
  typedef struct {bit sif, sid, bub, fid, fex; int fa, fb, st, sc, fc, cyc;} exp_t;

  ins_t past[$];          // instructions that left ID, youngest first
  int   m_state, m_stall, m_flush, cyc;
  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;

  function automatic int fwd(bit u, int a);
    if (!u) return 0;
    for (int i = 0; i < 3; i++)
      if (past[i].v && past[i].we && past[i].rd == a && !(i == 0 && past[i].ld)) return i + 1;
    return 0;
  endfunction

  function automatic stim_t nop();
    stim_t s = '{default: 0};
    return s;
  endfunction
  function automatic stim_t alu(int rd, int ra, int rb);
    stim_t s = nop();
    s.v = 1; s.ua = 1; s.ub = 1; s.we = 1; s.rd = rd; s.ra = ra; s.rb = rb;
    return s;
  endfunction
  function automatic stim_t ldr(int rd, int ra);
    stim_t s = nop();
    s.v = 1; s.ua = 1; s.we = 1; s.ld = 1; s.rd = rd; s.ra = ra;
    return s;
  endfunction
  function automatic stim_t cmp(int ra, int rb);
    stim_t s = nop();
    s.v = 1; s.ua = 1; s.ub = 1; s.sf = 1; s.ra = ra; s.rb = rb;
    return s;
  endfunction
  function automatic stim_t jcc();
    stim_t s = nop();
    s.v = 1; s.cb = 1;
    return s;
  endfunction
  function automatic stim_t rnd();
    stim_t s;
    int k = $urandom_range(0, 5);
    int a = $urandom_range(0, 3), b = $urandom_range(0, 3), d = $urandom_range(0, 3);
    case (k)
      0, 1:    s = alu(d, a, b);
      2:       s = ldr(d, a);
      3:       s = cmp(a, b);
      4:       s = jcc();
      default: begin s = alu(d, a, b); s.ub = 0; end
    endcase
    s.v    = ($urandom_range(0, 4) != 0);
    s.br   = ($urandom_range(0, 7) == 0);
    s.hold = ($urandom_range(0, 9) == 0);
    s.rst  = ($urandom_range(0, 199) == 0);
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   lu, fh, hz;
    @(posedge clk); #1;
    reset            = s.rst;
    hif.id_valid     = s.v;
    hif.id_ra        = AW'(s.ra);
    hif.id_rb        = AW'(s.rb);
    hif.id_rd        = AW'(s.rd);
    hif.id_use_ra    = s.ua;
    hif.id_use_rb    = s.ub;
    hif.id_we        = s.we;
    hif.id_load      = s.ld;
    hif.id_set_flags = s.sf;
    hif.id_cond_br   = s.cb;
    hif.ex_br_taken  = s.br;
    hif.ext_hold     = s.hold;
    cyc++;
    if (s.rst) begin
      past.delete();
      repeat (3) past.push_back('{v: 0, we: 0, ld: 0, sf: 0, rd: 0});
      m_state = 0; m_stall = 0; m_flush = 0;
    end
    lu = s.v && past[0].v && past[0].ld && past[0].we &&
         ((s.ua && s.ra == past[0].rd) || (s.ub && s.rb == past[0].rd));
    fh = s.v && s.cb && past[0].v && past[0].sf;
    hz = !s.br && (lu || fh);
    e.sif = !s.rst && (s.hold || hz);
    e.sid = e.sif;
    e.bub = !s.rst && !s.hold && hz;
    e.fid = !s.rst && !s.hold && s.br;
    e.fex = e.fid;
    e.fa  = fwd(s.ua, s.ra);
    e.fb  = fwd(s.ub, s.rb);
    e.st  = m_state; e.sc = m_stall; e.fc = m_flush; e.cyc = cyc;
    exp_q.push_back(e);
    if (!s.rst && !s.hold) begin
      m_state = s.br ? 3 : lu ? 1 : fh ? 2 : 0;
      if (m_state inside {1, 2} && m_stall < SAT) m_stall++;
      if (m_state == 3 && m_flush < SAT) m_flush++;
      past.push_front('{v: s.v && !hz && !s.br, we: s.we, ld: s.ld, sf: s.sf, rd: s.rd});
      void'(past.pop_back());
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x, input int c);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, a, x);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall_if",  32'(hif.stall_if),  32'(e.sif), e.cyc);
      chk("stall_id",  32'(hif.stall_id),  32'(e.sid), e.cyc);
      chk("bubble_ex", 32'(hif.bubble_ex), 32'(e.bub), e.cyc);
      chk("flush_id",  32'(hif.flush_id),  32'(e.fid), e.cyc);
      chk("flush_ex",  32'(hif.flush_ex),  32'(e.fex), e.cyc);
      chk("fwd_a",     32'(hif.fwd_a),     32'(e.fa),  e.cyc);
      chk("fwd_b",     32'(hif.fwd_b),     32'(e.fb),  e.cyc);
      chk("state",     32'(hif.state),     32'(e.st),  e.cyc);
      chk("stall_cnt", 32'(hif.stall_cnt), 32'(e.sc),  e.cyc);
      chk("flush_cnt", 32'(hif.flush_cnt), 32'(e.fc),  e.cyc);
    end
  end

  initial begin
    stim_t s;
    s = nop(); s.rst = 1;
    step(s); step(s);
    step(nop());
    // ADD R1,R2,R3 ; ADD R4,R1,R5 -> EX forward
    step(alu(1, 2, 3)); step(alu(4, 1, 5)); step(nop());
    // LDR R5,32(R6) ; ADD R1,R5,R2 held in ID across the stall, then MEM forward
    step(ldr(5, 6)); step(alu(1, 5, 2)); step(alu(1, 5, 2)); step(nop());
    // CMP ; JEQ stalls once, CMP then two ALU ops then JNE does not
    step(cmp(0, 1)); step(jcc()); step(jcc());
    step(cmp(3, 3)); step(alu(7, 8, 9)); step(alu(10, 11, 12)); step(jcc());
    // taken branch beats load-use
    step(ldr(5, 6)); s = alu(1, 5, 2); s.br = 1; step(s); step(nop());
    // external hold for 3 cycles over a load-use
    step(ldr(5, 6)); s = alu(1, 5, 2); s.hold = 1;
    repeat (3) step(s);
    s.hold = 0; step(s); step(s); step(nop());
    // reset in the stall cycle, no residual bubble after release
    step(ldr(5, 6)); s = alu(1, 5, 2); s.rst = 1; step(s);
    s.rst = 0; step(s); step(nop());
    repeat (3000) step(rnd());
    s = nop(); step(s);
    // drive both counters into saturation
    repeat (SAT + 20) begin step(ldr(1, 2)); step(alu(3, 1, 1)); end
    s = nop(); s.br = 1;
    repeat (SAT + 20) step(s);
    step(nop()); step(nop());
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR_W, default 4, register-address width (16 architectural registers).
REQ-002 Parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 id_valid  input  1  the ID stage holds a real instruction.
REQ-006 id_ra, id_rb  input  REG_ADDR_W each  source register addresses read by the ID-stage register file.
REQ-007 id_use_ra, id_use_rb  input  1 each  the ID instruction actually reads that source.
REQ-008 id_rd  input  REG_ADDR_W  destination register of the ID instruction.
REQ-009 id_we  input  1  the ID instruction writes id_rd (ADD/SUB/LDR).
REQ-010 id_load  input  1  the ID instruction is LDR.
REQ-011 id_set_flags  input  1  the ID instruction is CMP.
REQ-012 id_cond_br  input  1  the ID instruction is JEQ or JNE (reads flags).
REQ-013 ex_br_taken  input  1  the branch in EX resolved taken (JMP, or a satisfied JEQ/JNE).
REQ-014 ext_hold  input  1  memory busy; freeze the whole pipeline.
REQ-015 stall_if, stall_id  output  1 each  hold the PC and the IF/ID register.
REQ-016 bubble_ex  output  1  load an empty bubble into the ID/EX register.
REQ-017 flush_id, flush_ex  output  1 each  squash the IF/ID and ID/EX contents.
REQ-018 fwd_a, fwd_b  output  2 each  operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
REQ-019 state  output  2  last-cycle action: 00 RUN, 01 LD_STALL, 10 FLAG_STALL, 11 FLUSH.
REQ-020 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-021 The block SHALL keep a shadow tracker for the EX, MEM and WB stages, holding valid, rd, we, load and set_flags per stage.
REQ-022 On each edge without a hold: EX receives the ID fields (valid forced to 0 on bubble or flush), MEM receives EX, and WB receives MEM.
REQ-023 Load-use hazard: ex.valid & ex.load & ex.we, and (id_use_ra & id_ra==ex.rd or id_use_rb & id_rb==ex.rd), with id_valid. The block SHALL assert stall_if, stall_id and bubble_ex for exactly 1 cycle.
REQ-024 Flag hazard: id_valid & id_cond_br & ex.valid & ex.set_flags. The block SHALL stall and bubble for exactly 1 cycle.
REQ-025 Taken branch: ex_br_taken=1. The block SHALL assert flush_id and flush_ex in the same cycle, deassert all stalls, and invalidate the tracker EX entry written at that edge.
REQ-026 Priority SHALL be ext_hold > ex_br_taken > load-use > flag.
REQ-027 ext_hold=1 SHALL assert stall_if and stall_id, deassert bubble and flush, freeze the tracker, counters and state, and be ignored for counting.
REQ-028 Forward select per source (used and address match) SHALL be the youngest match in this order:
 - EX, when EX is valid, we and not load (01);
 - MEM, when valid and we (10);
 - WB, when valid and we (11);
 - otherwise 00.
 An unused source SHALL select 00.
REQ-029 A load in EX SHALL never be selected as a forward source; after the 1-cycle stall it SHALL be selected from MEM (10).
REQ-030 stall/bubble/flush/fwd SHALL be combinational from the tracker and inputs with 0-cycle latency; state and counters SHALL be registered.
REQ-031 state SHALL record the action applied in the previous non-held cycle.
REQ-032 stall_cnt SHALL increment once per LD_STALL or FLAG_STALL cycle; flush_cnt SHALL increment once per FLUSH cycle; both SHALL saturate at all-ones with no wrap.
REQ-033 id_valid=0 SHALL never cause a stall.

Reset
REQ-034 Reset SHALL clear all tracker valid bits and counters, and set state to RUN, asynchronously.
REQ-035 While reset=1, every output except fwd_a/fwd_b SHALL be 0; fwd_a/fwd_b SHALL be 00 because all tracker entries are invalid.
REQ-036 Reset asserted mid-stall SHALL drop the stall at once, with no residual bubble after release.

Structure
REQ-037 A shared package SHALL hold the 2-bit state enum (RUN, LD_STALL, FLAG_STALL, FLUSH), the forward-select constants FWD_RF/EX/MEM/WB, and the tracker-entry struct.
REQ-038 One sub-module, hazard_fwd_sel, SHALL compute the forward select for one source and be instantiated twice (fwd_a, fwd_b).

Verification
REQ-039 ADD R1,R2,R3 then ADD R4,R1,R5 -> no stall; fwd_a=01 in the second instruction's ID cycle.
REQ-040 LDR R5,32(R6) then ADD R1,R5,R2 -> 1 cycle stall_if=stall_id=bubble_ex=1, state=LD_STALL next, then fwd_a=10; stall_cnt=1.
REQ-041 CMP R0,R1 then JEQ 0x0 -> 1-cycle flag stall; CMP R3,R3 then two non-flag instructions then JNE -> no stall.
REQ-042 ex_br_taken=1 together with a load-use condition -> flush_id=flush_ex=1, stall_if=0, flush_cnt=1, stall_cnt unchanged.
REQ-043 ext_hold=1 for 3 cycles during a load-use stall -> tracker, state and counters frozen; the stall completes exactly 1 cycle after release.
REQ-044 Reset pulse mid-stall, then 0x10000 forced stalls -> all outputs 0 during reset; stall_cnt saturates at 0xFFFF.
